// File: rtl/nx_stream_arbiter_if.sv
// Message payload type and the grouped inbound/outbound stream interface
// used by nx_stream_arbiter.
package nx_stream_pkg;

  localparam int unsigned SRC_W     = 4;
  localparam int unsigned KIND_W    = 4;
  localparam int unsigned PAYLOAD_W = 24;

  typedef struct packed {
    logic [SRC_W-1:0]     src;
    logic [KIND_W-1:0]    kind;
    logic [PAYLOAD_W-1:0] payload;
  } node_message_t;

endpackage

interface nx_stream_arbiter_if #(
  parameter int unsigned INPUTS = 4
);
  import nx_stream_pkg::*;

  node_message_t           inbound_data [INPUTS];
  logic [INPUTS-1:0]       inbound_valid;
  logic [INPUTS-1:0]       inbound_ready;
  node_message_t           outbound_data;
  logic                    outbound_valid;
  logic                    outbound_ready;

  // Producer/consumer environment side.
  modport master (
    output inbound_data,
    output inbound_valid,
    input  inbound_ready,
    input  outbound_data,
    input  outbound_valid,
    output outbound_ready
  );

  // Arbiter side.
  modport slave (
    input  inbound_data,
    input  inbound_valid,
    output inbound_ready,
    output outbound_data,
    output outbound_valid,
    input  outbound_ready
  );

endinterface

// File: rtl/nx_stream_arbiter.sv
// Work-conserving round-robin merge of INPUTS message streams into one
// registered output slot; drain and refill may happen in the same cycle.
module nx_stream_arbiter #(
  parameter int unsigned INPUTS = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  nx_stream_arbiter_if.slave bus
);
  import nx_stream_pkg::*;

  localparam int unsigned PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int unsigned IDX_W = PTR_W + 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t       state;
  slot_state_t       state_next;
  node_message_t     data_q;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_found;
  logic [IDX_W-1:0]  cand;
  logic              out_valid;
  logic              slot_free;
  logic              accept;
  logic [INPUTS-1:0] ready_c;

  assign out_valid = (state == SLOT_FULL);
  assign slot_free = !out_valid || bus.outbound_ready;

  // Rotating priority search starting at ptr, wrapping modulo INPUTS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      cand = IDX_W'(ptr) + IDX_W'(i);
      if (cand >= IDX_W'(INPUTS)) begin
        cand = cand - IDX_W'(INPUTS);
      end
      if (!grant_found && bus.inbound_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign accept = grant_found && slot_free && !i_rst;

  // Ready is one-hot on the winner only, masked during reset and stall.
  always_comb begin
    ready_c = '0;
    if (accept) begin
      ready_c[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (accept) begin
      if (grant_idx == PTR_W'(INPUTS - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = grant_idx + PTR_W'(1);
      end
    end
  end

  // Slot occupancy next-state: refill wins over drain.
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = SLOT_FULL;
    end else if (out_valid && bus.outbound_ready) begin
      state_next = SLOT_EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

  // Data holds its last value after a drain; only a grant reloads it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q <= '0;
    end else if (accept) begin
      data_q <= bus.inbound_data[grant_idx];
    end
  end

  assign bus.inbound_ready  = ready_c;
  assign bus.outbound_valid = out_valid;
  assign bus.outbound_data  = data_q;

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Self-checking bench for nx_stream_arbiter: directed vector table plus
// randomized traffic against a cycle-level behavioural model.
module tb_nx_stream_arbiter;
  import nx_stream_pkg::*;

  localparam int unsigned INPUTS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  nx_stream_arbiter_if #(.INPUTS(INPUTS)) bus ();

  nx_stream_arbiter #(.INPUTS(INPUTS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [3:0] exp_src;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  int            m_ptr;
  logic          m_valid;
  node_message_t m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [3:0] v, input int ptr);
    for (int i = 0; i < INPUTS; i++) begin
      if (v[(ptr + i) % INPUTS]) return (ptr + i) % INPUTS;
    end
    return -1;
  endfunction

  task automatic add(input logic r, input logic [3:0] v, input logic o,
                     input logic [3:0] er, input logic ev, input logic [3:0] es);
    vec_t t;
    t.rst = r; t.valid = v; t.ordy = o;
    t.exp_ready = er; t.exp_valid = ev; t.exp_src = es;
    vecs.push_back(t);
  endtask

  task automatic tag_inputs();
    for (int k = 0; k < INPUTS; k++) begin
      bus.inbound_data[k].src     = 4'(k);
      bus.inbound_data[k].kind    = 4'h5;
      bus.inbound_data[k].payload = 24'(k + 100);
    end
  endtask

  initial begin
    bus.inbound_valid  = '0;
    bus.outbound_ready = 1'b0;
    tag_inputs();

    // Reset with all inputs valid
    for (int i = 0; i < 4; i++) add(1, 4'hF, 1, 4'b0000, 0, 0);
    // Full-load rotation, latency 1
    add(0, 4'hF, 1, 4'b0001, 0, 0);
    add(0, 4'hF, 1, 4'b0010, 1, 0);
    add(0, 4'hF, 1, 4'b0100, 1, 1);
    add(0, 4'hF, 1, 4'b1000, 1, 2);
    add(0, 4'hF, 1, 4'b0001, 1, 3);
    add(0, 4'hF, 1, 4'b0010, 1, 0);
    // Backpressure: slot holds input 1, pointer frozen at 2
    for (int i = 0; i < 5; i++) add(0, 4'hF, 0, 4'b0000, 1, 1);
    add(0, 4'hF, 1, 4'b0100, 1, 1);
    add(0, 4'h0, 1, 4'b0000, 1, 2);
    // Sparse requests on inputs 1 and 3
    add(0, 4'hA, 1, 4'b1000, 0, 0);
    add(0, 4'hA, 1, 4'b0010, 1, 3);
    add(0, 4'hA, 1, 4'b1000, 1, 1);
    add(0, 4'hA, 1, 4'b0010, 1, 3);
    add(0, 4'h0, 0, 4'b0000, 1, 1);
    // Drain and refill from input 2 in the same cycle
    add(0, 4'h4, 1, 4'b0100, 1, 1);
    add(0, 4'h0, 1, 4'b0000, 1, 2);
    add(0, 4'h0, 1, 4'b0000, 0, 0);
    // Mid-stream reset discards a held message and returns pointer to 0
    add(0, 4'h1, 0, 4'b0001, 0, 0);
    add(1, 4'h0, 0, 4'b0000, 1, 0);
    add(0, 4'hF, 1, 4'b0001, 0, 0);
    add(0, 4'hF, 1, 4'b0010, 1, 0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst                = vecs[i].rst;
      bus.inbound_valid  = vecs[i].valid;
      bus.outbound_ready = vecs[i].ordy;
      #2;
      check($sformatf("vec%0d_ready", i), 64'(bus.inbound_ready), 64'(vecs[i].exp_ready));
      check($sformatf("vec%0d_valid", i), 64'(bus.outbound_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_src", i), 64'(bus.outbound_data.src), 64'(vecs[i].exp_src));
      @(posedge clk);
      #1;
    end

    // Hand-written: reset during a stall with all valid, then zero data on release
    rst = 1'b1; bus.inbound_valid = 4'hF; bus.outbound_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check("rst_stall_valid", 64'(bus.outbound_valid), 64'(0));
    check("rst_stall_data", 64'(bus.outbound_data), 64'(0));
    check("rst_stall_grant0", 64'(bus.inbound_ready), 64'(4'b0001));
    rst = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the model
    m_ptr = 0; m_valid = 1'b0; m_data = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      logic [3:0]    v;
      logic          o;
      logic          r;
      logic [3:0]    er;
      int            w;
      node_message_t in_msg [INPUTS];
      v = 4'($urandom);
      o = ($urandom_range(0, 9) < 7);
      r = (cyc < 2) || ($urandom_range(0, 49) == 0);
      for (int k = 0; k < INPUTS; k++) begin
        in_msg[k] = node_message_t'(32'($urandom));
        bus.inbound_data[k] = in_msg[k];
      end
      rst = r; bus.inbound_valid = v; bus.outbound_ready = o;
      #2;
      w  = winner(v, m_ptr);
      er = '0;
      if (!r && w >= 0 && (!m_valid || o)) er[w] = 1'b1;
      if (cyc >= 2) begin
        check("rnd_ready", 64'(bus.inbound_ready), 64'(er));
        check("rnd_valid", 64'(bus.outbound_valid), 64'(m_valid));
        check("rnd_data", 64'(bus.outbound_data), 64'(m_data));
      end
      @(posedge clk);
      #1;
      if (r) begin
        m_ptr = 0; m_valid = 1'b0; m_data = '0;
      end else if (er != 0) begin
        m_data  = in_msg[w];
        m_valid = 1'b1;
        m_ptr   = (w + 1) % INPUTS;
      end else if (m_valid && o) begin
        m_valid = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
